// File: rtl/axil_pkg.sv
// axil_pkg
// Shared definitions for the AXI4-Lite to single-port memory bridge:
// AXI response codes and the bridge sequencer state encoding.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2,
    WR_RESP = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/axil_hold_reg.sv
// axil_hold_reg
// One-entry holding register for an AXI valid/ready channel. The entry is
// captured on a handshake and released when the owning transaction issues.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    channel valid from the master
//   in_ready    channel ready to the master (high while the entry is empty)
//   in_data     channel payload
//   free        release the held entry (transaction issued)
//   held        entry is occupied
//   data        held payload
module axil_hold_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         free,
  output logic         held,
  output logic [W-1:0] data
);

  logic         held_q, held_d;
  logic [W-1:0] data_q, data_d;

  // Next-state: capture when empty and valid, release on free.
  always_comb begin
    held_d = held_q;
    data_d = data_q;
    if (held_q) begin
      if (free) begin
        held_d = 1'b0;
      end else begin
        held_d = 1'b1;
      end
    end else begin
      if (in_valid) begin
        held_d = 1'b1;
        data_d = in_data;
      end else begin
        held_d = 1'b0;
      end
    end
  end

  // Entry state and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= 1'b0;
      data_q <= {W{1'b0}};
    end else begin
      held_q <= held_d;
      data_q <= data_d;
    end
  end

  assign in_ready = !held_q;
  assign held     = held_q;
  assign data     = data_q;

endmodule

// File: rtl/axil_mem_bridge.sv
// axil_mem_bridge
// AXI4-Lite slave onto a single-port synchronous word memory (1-cycle read
// latency, byte-enabled writes). AR, AW and W are buffered independently;
// one transaction is in flight at a time, with round-robin arbitration
// between a pending read and a complete pending write. Accesses outside
// [BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_W/8) get SLVERR and never touch
// the memory.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axi_ar*/r*        AXI4-Lite read address / read data channels
//   s_axi_aw*/w*/b*     AXI4-Lite write address / data / response channels
//   mem_en, mem_we      memory strobe and per-byte write enable
//   mem_addr, mem_wdata memory word address and write data
//   mem_rdata           memory read data, valid the cycle after a read strobe
module axil_mem_bridge
  import axil_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic [ADDR_W-1:0]            s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_W-1:0]            s_axi_wdata,
  input  logic [DATA_W/8-1:0]          s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  output logic                         mem_en,
  output logic [DATA_W/8-1:0]          mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned MEM_AW   = $clog2(MEM_DEPTH);
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  // One extra bit so the window size itself is representable.
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(MEM_DEPTH * STRB_W);

  // Addresses below BASE_ADDR wrap to a large offset and fail the compare.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] offset;
    offset = addr - BASE_ADDR;
    return ({1'b0, offset} < MEM_BYTES);
  endfunction

  // Byte-offset bits are dropped; misaligned addresses hit the enclosing word.
  function automatic logic [MEM_AW-1:0] word_index(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] offset;
    offset = addr - BASE_ADDR;
    return MEM_AW'(offset >> ADDR_LSB);
  endfunction

  logic                     ar_held, aw_held, w_held;
  logic [ADDR_W-1:0]        ar_addr, aw_addr;
  logic [DATA_W+STRB_W-1:0] w_bundle;
  logic [DATA_W-1:0]        w_data;
  logic [STRB_W-1:0]        w_strb;
  logic                     rd_req, wr_req, rd_issue, wr_issue;
  logic                     ar_in_range, aw_in_range;

  bridge_state_e     state_q, state_d;
  logic              prio_wr_q, prio_wr_d;   // 1: write wins the next conflict
  logic              rd_err_q, rd_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              bvalid_q, bvalid_d;

  axil_hold_reg #(.W(ADDR_W)) u_ar_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s_axi_arvalid),
    .in_ready (s_axi_arready),
    .in_data  (s_axi_araddr),
    .free     (rd_issue),
    .held     (ar_held),
    .data     (ar_addr)
  );

  axil_hold_reg #(.W(ADDR_W)) u_aw_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s_axi_awvalid),
    .in_ready (s_axi_awready),
    .in_data  (s_axi_awaddr),
    .free     (wr_issue),
    .held     (aw_held),
    .data     (aw_addr)
  );

  axil_hold_reg #(.W(DATA_W + STRB_W)) u_w_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s_axi_wvalid),
    .in_ready (s_axi_wready),
    .in_data  ({s_axi_wdata, s_axi_wstrb}),
    .free     (wr_issue),
    .held     (w_held),
    .data     (w_bundle)
  );

  assign w_data      = w_bundle[DATA_W+STRB_W-1:STRB_W];
  assign w_strb      = w_bundle[STRB_W-1:0];
  assign ar_in_range = addr_in_range(ar_addr);
  assign aw_in_range = addr_in_range(aw_addr);
  assign rd_req      = (state_q == IDLE) && ar_held;
  assign wr_req      = (state_q == IDLE) && aw_held && w_held;

  // Grant: round-robin on conflict, otherwise whichever side is ready.
  always_comb begin
    rd_issue = 1'b0;
    wr_issue = 1'b0;
    if (rd_req && wr_req) begin
      if (prio_wr_q) begin
        wr_issue = 1'b1;
      end else begin
        rd_issue = 1'b1;
      end
    end else if (rd_req) begin
      rd_issue = 1'b1;
    end else if (wr_req) begin
      wr_issue = 1'b1;
    end else begin
      rd_issue = 1'b0;
      wr_issue = 1'b0;
    end
  end

  // Memory port: active only in the issue cycle of an in-range access.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = {STRB_W{1'b0}};
    mem_addr  = {MEM_AW{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (rd_issue && ar_in_range) begin
      mem_en   = 1'b1;
      mem_addr = word_index(ar_addr);
    end else if (wr_issue && aw_in_range) begin
      mem_en    = 1'b1;
      mem_we    = w_strb;
      mem_addr  = word_index(aw_addr);
      mem_wdata = w_data;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Sequencer next-state and response register updates.
  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    rd_err_d  = rd_err_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    rvalid_d  = 1'b0;
    bvalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req && wr_req) begin
          prio_wr_d = !prio_wr_q;
        end else begin
          prio_wr_d = prio_wr_q;
        end
        if (rd_issue) begin
          state_d  = RD_WAIT;
          rd_err_d = !ar_in_range;
        end else if (wr_issue) begin
          state_d = WR_RESP;
          bresp_d = aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        state_d = RD_RESP;
        rdata_d = rd_err_q ? {DATA_W{1'b0}} : mem_rdata;
        rresp_d = rd_err_q ? RESP_SLVERR : RESP_OKAY;
      end
      // rvalid is registered from the state, so it appears one cycle into RD_RESP.
      RD_RESP: begin
        if (rvalid_q && s_axi_rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_wr_q <= 1'b0;
      rd_err_q  <= 1'b0;
      rdata_q   <= {DATA_W{1'b0}};
      rresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      rd_err_q  <= rd_err_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
    end
  end

  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_bvalid = bvalid_q;

endmodule

// File: tb/tb_axil_mem_bridge.sv
// tb_axil_mem_bridge
// Directed bench for axil_mem_bridge with default parameters (32-bit data,
// 1024 words at base 0). A behavioural single-port memory sits on the mem_*
// port and a monitor logs every memory strobe so grant order can be checked.
module tb_axil_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          failures = 0;
  int          g_cnt = 0;
  logic [3:0]  g_we   [0:63];
  logic [9:0]  g_addr [0:63];
  logic [31:0] mem    [0:1023];
  logic        load_mem;

  always #5 clk = ~clk;

  axil_mem_bridge dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      1:       return 32'hA1B2_C3D4;
      2:       return 32'hDEAD_BEEF;
      3:       return 32'h0BAD_F00D;
      default: return 32'h1000_0000 + 32'(i);
    endcase
  endfunction

  // Behavioural single-port memory, read-before-write, 1-cycle read latency.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= mem[mem_addr];
    end
  end

  // Log of every memory strobe (write enable and word address).
  always @(posedge clk) begin
    if (mem_en && g_cnt < 64) begin
      g_we[g_cnt]   <= mem_we;
      g_addr[g_cnt] <= mem_addr;
      g_cnt         <= g_cnt + 1;
    end
  end

  // Present the requested channels together; return after the handshake edge.
  task automatic drive_req(input bit do_ar, input logic [31:0] ar_a,
                           input bit do_aw, input logic [31:0] aw_a,
                           input bit do_w, input logic [31:0] d, input logic [3:0] s,
                           output bit ok, output time t_hs);
    int n;
    @(negedge clk);
    if (do_ar) begin s_axi_araddr = ar_a; s_axi_arvalid = 1'b1; end
    if (do_aw) begin s_axi_awaddr = aw_a; s_axi_awvalid = 1'b1; end
    if (do_w)  begin s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1; end
    n = 0;
    while (n < 50 && !((!do_ar || s_axi_arready) && (!do_aw || s_axi_awready) &&
                       (!do_w || s_axi_wready))) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 50);
    @(posedge clk);
    t_hs = $time;
    #1;
    s_axi_arvalid = 1'b0;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
  endtask

  // Wait (bounded) for rvalid; completes the handshake if rready is high.
  task automatic wait_r(output logic [31:0] d, output logic [1:0] r, output time t, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
    ok = s_axi_rvalid;
    d  = s_axi_rdata;
    r  = s_axi_rresp;
    t  = $time;
    if (s_axi_rready) begin @(posedge clk); #1; end
  endtask

  // Wait (bounded) for bvalid; completes the handshake (bready is held high).
  task automatic wait_b(output logic [1:0] r, output time t, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    ok = s_axi_bvalid;
    r  = s_axi_bresp;
    t  = $time;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_mem = 1'b1;
    s_axi_araddr = 32'h0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    s_axi_awaddr = 32'h0; s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    repeat (2) @(negedge clk);
    load_mem = 1'b0;
    checks++;
    if ({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid} !== 5'b11100) begin
      failures++;
      $display("FAIL reset_handshake: got %b expected 11100",
               {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid});
    end
    checks++;
    if ({s_axi_rresp, s_axi_bresp, s_axi_rdata} !== 36'h0) begin
      failures++;
      $display("FAIL reset_resp: got %h expected 0", {s_axi_rresp, s_axi_bresp, s_axi_rdata});
    end
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 47'h0) begin
      failures++;
      $display("FAIL reset_mem: got %h expected 0", {mem_en, mem_we, mem_addr, mem_wdata});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    int g0; bit ok1, ok2; time t_hs, t_rv; logic [31:0] d; logic [1:0] r;
    g0 = g_cnt;
    drive_req(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, ok1, t_hs);
    wait_r(d, r, t_rv, ok2);
    checks++;
    if (!(ok1 && ok2)) begin failures++; $display("FAIL rd_handshake: got %b%b expected 11", ok1, ok2); end
    checks++;
    if (t_rv - t_hs !== 64'd35) begin failures++; $display("FAIL rd_latency: got %0t expected 35", t_rv - t_hs); end
    checks++;
    if ({r, d} !== {2'b00, 32'hDEAD_BEEF}) begin failures++; $display("FAIL rd_data: got %h/%h expected 0/deadbeef", r, d); end
    checks++;
    if (g_cnt !== g0 + 1 || {g_we[g0], g_addr[g0]} !== {4'h0, 10'd2}) begin
      failures++;
      $display("FAIL rd_mem_access: got cnt=%0d we=%h addr=%0d expected cnt=%0d we=0 addr=2",
               g_cnt - g0, g_we[g0], g_addr[g0], 1);
    end
    @(negedge clk);
    checks++;
    if (s_axi_rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_drop: got %b expected 0", s_axi_rvalid); end
  endtask

  task automatic test_write_split();
    int g0; bit ok1, ok2, ok3; time t_hs, t_b, t_rv; logic [31:0] d; logic [1:0] r;
    g0 = g_cnt;
    drive_req(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1122_3344, 4'b0101, ok1, t_hs);
    repeat (4) @(negedge clk);
    checks++;
    if (s_axi_wready !== 1'b0 || g_cnt !== g0) begin
      failures++;
      $display("FAIL wr_w_only_waits: got wready=%b strobes=%0d expected wready=0 strobes=0", s_axi_wready, g_cnt - g0);
    end
    drive_req(1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0, 4'h0, ok2, t_hs);
    wait_b(r, t_b, ok3);
    checks++;
    if (!(ok1 && ok2 && ok3) || t_b - t_hs !== 64'd25 || r !== 2'b00) begin
      failures++;
      $display("FAIL wr_resp: got ok=%b%b%b lat=%0t bresp=%b expected ok=111 lat=25 bresp=00", ok1, ok2, ok3, t_b - t_hs, r);
    end
    checks++;
    if (g_cnt !== g0 + 1 || {g_we[g0], g_addr[g0]} !== {4'b0101, 10'd1}) begin
      failures++;
      $display("FAIL wr_mem_access: got cnt=%0d we=%b addr=%0d expected cnt=1 we=0101 addr=1", g_cnt - g0, g_we[g0], g_addr[g0]);
    end
    drive_req(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, ok1, t_hs);
    wait_r(d, r, t_rv, ok2);
    checks++;
    if (!ok2 || {r, d} !== {2'b00, 32'hA122_C344}) begin
      failures++;
      $display("FAIL wr_readback: got %b/%h expected 00/a122c344", r, d);
    end
  endtask

  task automatic test_zero_strb();
    int g0; bit ok1, ok2; time t_hs, t_b; logic [1:0] r;
    g0 = g_cnt;
    drive_req(1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'hFFFF_FFFF, 4'h0, ok1, t_hs);
    wait_b(r, t_b, ok2);
    checks++;
    if (!ok2 || r !== 2'b00 || g_cnt !== g0 + 1 || {g_we[g0], g_addr[g0]} !== {4'h0, 10'd2}) begin
      failures++;
      $display("FAIL zero_strb: got bresp=%b cnt=%0d we=%h addr=%0d expected bresp=00 cnt=1 we=0 addr=2",
               r, g_cnt - g0, g_we[g0], g_addr[g0]);
    end
    checks++;
    if (mem[2] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL zero_strb_mem: got %h expected deadbeef", mem[2]); end
  endtask

  task automatic test_out_of_range();
    int g0; bit ok1, ok2; time t_hs, t_x; logic [31:0] d; logic [1:0] r;
    g0 = g_cnt;
    drive_req(1'b0, 32'h0, 1'b1, 32'h1000, 1'b1, 32'h5555_AAAA, 4'hF, ok1, t_hs);
    wait_b(r, t_x, ok2);
    checks++;
    if (!ok2 || r !== 2'b10) begin failures++; $display("FAIL oor_bresp: got %b expected 10", r); end
    drive_req(1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, ok1, t_hs);
    wait_r(d, r, t_x, ok2);
    checks++;
    if (!ok2 || {r, d} !== {2'b10, 32'h0}) begin failures++; $display("FAIL oor_read: got %b/%h expected 10/00000000", r, d); end
    checks++;
    if (g_cnt !== g0) begin failures++; $display("FAIL oor_mem_en: got %0d strobes expected 0", g_cnt - g0); end
    drive_req(1'b1, 32'hFFC, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, ok1, t_hs);
    wait_r(d, r, t_x, ok2);
    checks++;
    if (!ok2 || {r, d} !== {2'b00, 32'h1000_03FF}) begin failures++; $display("FAIL last_word: got %b/%h expected 00/100003ff", r, d); end
  endtask

  task automatic test_arbitration();
    int g0; bit ok1, ok2, ok3, ok4, ok5, ok6, ok7; time t_hs, t_x;
    logic [31:0] d1, d2; logic [1:0] r1, r2, b1, b2;
    g0 = g_cnt;
    drive_req(1'b1, 32'h8, 1'b1, 32'h10, 1'b1, 32'hCAFE_0004, 4'hF, ok1, t_hs);
    drive_req(1'b1, 32'hC, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, ok2, t_hs);
    wait_r(d1, r1, t_x, ok3);
    drive_req(1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 32'hCAFE_0005, 4'hF, ok4, t_hs);
    wait_b(b1, t_x, ok5);
    wait_r(d2, r2, t_x, ok6);
    wait_b(b2, t_x, ok7);
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4 && ok5 && ok6 && ok7)) begin
      failures++;
      $display("FAIL arb_handshakes: got %b%b%b%b%b%b%b expected 1111111", ok1, ok2, ok3, ok4, ok5, ok6, ok7);
    end
    checks++;
    if ({r1, d1, r2, d2, b1, b2} !== {2'b00, 32'hDEAD_BEEF, 2'b00, 32'h0BAD_F00D, 2'b00, 2'b00}) begin
      failures++;
      $display("FAIL arb_responses: got r1=%b/%h r2=%b/%h b1=%b b2=%b expected 00/deadbeef 00/0badf00d 00 00",
               r1, d1, r2, d2, b1, b2);
    end
    checks++;
    if (g_cnt !== g0 + 4 ||
        {g_we[g0], g_addr[g0], g_we[g0+1], g_addr[g0+1], g_we[g0+2], g_addr[g0+2], g_we[g0+3], g_addr[g0+3]} !==
        {4'h0, 10'd2, 4'hF, 10'd4, 4'h0, 10'd3, 4'hF, 10'd5}) begin
      failures++;
      $display("FAIL arb_order: got cnt=%0d %h/%0d %h/%0d %h/%0d %h/%0d expected 4 0/2 f/4 0/3 f/5", g_cnt - g0,
               g_we[g0], g_addr[g0], g_we[g0+1], g_addr[g0+1], g_we[g0+2], g_addr[g0+2], g_we[g0+3], g_addr[g0+3]);
    end
    checks++;
    if ({mem[4], mem[5]} !== {32'hCAFE_0004, 32'hCAFE_0005}) begin
      failures++;
      $display("FAIL arb_mem: got %h %h expected cafe0004 cafe0005", mem[4], mem[5]);
    end
  endtask

  task automatic test_stall();
    int g0; bit ok1, ok2, ok3; time t_hs, t_x; logic [31:0] d; logic [1:0] r;
    g0 = g_cnt;
    s_axi_rready = 1'b0;
    drive_req(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, ok1, t_hs);
    wait_r(d, r, t_x, ok2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin
        failures++;
        $display("FAIL stall_stable[%0d]: got %b/%h/%b expected 1/deadbeef/00", i, s_axi_rvalid, s_axi_rdata, s_axi_rresp);
      end
    end
    checks++;
    if (s_axi_arready !== 1'b1) begin failures++; $display("FAIL stall_arready: got %b expected 1", s_axi_arready); end
    drive_req(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, ok3, t_hs);
    @(negedge clk);
    checks++;
    if (!(ok1 && ok2 && ok3) || s_axi_arready !== 1'b0 || g_cnt !== g0 + 1) begin
      failures++;
      $display("FAIL stall_second_ar: got ok=%b%b%b arready=%b strobes=%0d expected ok=111 arready=0 strobes=1",
               ok1, ok2, ok3, s_axi_arready, g_cnt - g0);
    end
    s_axi_rready = 1'b1;
    @(posedge clk);
    #1;
    wait_r(d, r, t_x, ok1);
    checks++;
    if (!ok1 || {r, d} !== {2'b00, 32'hA122_C344} || g_cnt !== g0 + 2) begin
      failures++;
      $display("FAIL stall_second_rd: got %b/%h strobes=%0d expected 00/a122c344 strobes=2", r, d, g_cnt - g0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2, seen; time t_hs, t_rv; logic [31:0] d; logic [1:0] r;
    drive_req(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, ok1, t_hs);
    checks++;
    if (mem_en !== 1'b1) begin failures++; $display("FAIL issue_mem_en: got %b expected 1", mem_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we} !== 5'b0) begin failures++; $display("FAIL async_mem_drop: got %b expected 00000", {mem_en, mem_we}); end
    @(negedge clk); rst_n = 1'b1;
    drive_req(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, ok1, t_hs);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid, s_axi_rresp, s_axi_bresp,
         s_axi_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== {5'b11100, 83'h0}) begin
      failures++;
      $display("FAIL mid_reset_values: got %h expected %h",
               {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid, s_axi_rresp, s_axi_bresp,
                s_axi_rdata, mem_en, mem_we, mem_addr, mem_wdata}, {5'b11100, 83'h0});
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (s_axi_rvalid || s_axi_bvalid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL dropped_resp: got %b expected 0", seen); end
    drive_req(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, ok1, t_hs);
    wait_r(d, r, t_rv, ok2);
    checks++;
    if (!(ok1 && ok2) || t_rv - t_hs !== 64'd35 || {r, d} !== {2'b00, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL post_reset_read: got ok=%b%b lat=%0t %b/%h expected ok=11 lat=35 00/deadbeef",
               ok1, ok2, t_rv - t_hs, r, d);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_split();
    test_zero_strb();
    test_out_of_range();
    test_arbitration();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
